// File: rtl/ps2_ascii_fifo.sv
// ps2_ascii_fifo
//   Translates decoded PS/2 scan-set-2 make/break events into US-layout ASCII.
//   It tracks shift, ctrl, alt and caps lock, and queues the resulting
//   characters in a circular FIFO behind a valid/ready interface.
//
// Parameters
//   FIFO_DEPTH : FIFO entries (power of two, 2..256)
//   CTRL_EN    : 1 -> ctrl+letter yields control codes 0x01-0x1A
//   ALT_MODE   : 0 ignore alt, 1 set bit 7, 2 suppress character
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   key_data_stb              : one-cycle event strobe
//   key_broken / key_extended : break flag / E0 prefix flag
//   key_data                  : scan code with prefixes removed
//   ascii_valid / ascii_data  : FIFO head (data gated to 0 while empty)
//   ascii_ready               : consumer pops the head when valid & ready
//   fifo_count                : occupied entries
//   overflow / overflow_clr   : sticky drop flag and its clear (set wins)
//   caps_led                  : caps-lock state
module ps2_ascii_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int CTRL_EN    = 1,
  parameter int ALT_MODE   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_data_stb,
  input  logic                          key_broken,
  input  logic                          key_extended,
  input  logic [7:0]                    key_data,
  output logic                          ascii_valid,
  output logic [7:0]                    ascii_data,
  input  logic                          ascii_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          caps_led
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Letter position in the alphabet (1..26), 0 when the code is not a letter.
  function automatic logic [4:0] letter_idx(input logic [7:0] code);
    logic [4:0] idx;
    case (code)
      8'h1C: idx = 5'd1;   8'h32: idx = 5'd2;   8'h21: idx = 5'd3;
      8'h23: idx = 5'd4;   8'h24: idx = 5'd5;   8'h2B: idx = 5'd6;
      8'h34: idx = 5'd7;   8'h33: idx = 5'd8;   8'h43: idx = 5'd9;
      8'h3B: idx = 5'd10;  8'h42: idx = 5'd11;  8'h4B: idx = 5'd12;
      8'h3A: idx = 5'd13;  8'h31: idx = 5'd14;  8'h44: idx = 5'd15;
      8'h4D: idx = 5'd16;  8'h15: idx = 5'd17;  8'h2D: idx = 5'd18;
      8'h1B: idx = 5'd19;  8'h2C: idx = 5'd20;  8'h3C: idx = 5'd21;
      8'h2A: idx = 5'd22;  8'h1D: idx = 5'd23;  8'h22: idx = 5'd24;
      8'h35: idx = 5'd25;  8'h1A: idx = 5'd26;
      default: idx = 5'd0;
    endcase
    return idx;
  endfunction

  // Returns {produce, character} for a make event under the given modifiers.
  function automatic logic [8:0] xlate(input logic [7:0] code, input logic ext,
                                       input logic shift, input logic caps,
                                       input logic ctrl, input logic alt);
    logic       v;
    logic [7:0] ch;
    logic [4:0] li;
    v  = 1'b1;
    ch = 8'h00;
    li = letter_idx(code);
    if (ext) begin
      // Keypad Enter is the only extended key that yields a character.
      v  = (code == 8'h5A);
      ch = 8'h0D;
    end else if (li != 5'd0) begin
      if ((CTRL_EN != 0) && ctrl) ch = {3'b000, li};
      else if (caps ^ shift)      ch = 8'h40 + {3'b000, li};
      else                        ch = 8'h60 + {3'b000, li};
    end else begin
      case (code)
        8'h16: ch = shift ? 8'h21 : 8'h31;
        8'h1E: ch = shift ? 8'h40 : 8'h32;
        8'h26: ch = shift ? 8'h23 : 8'h33;
        8'h25: ch = shift ? 8'h24 : 8'h34;
        8'h2E: ch = shift ? 8'h25 : 8'h35;
        8'h36: ch = shift ? 8'h5E : 8'h36;
        8'h3D: ch = shift ? 8'h26 : 8'h37;
        8'h3E: ch = shift ? 8'h2A : 8'h38;
        8'h46: ch = shift ? 8'h28 : 8'h39;
        8'h45: ch = shift ? 8'h29 : 8'h30;
        8'h0E: ch = shift ? 8'h7E : 8'h60;
        8'h4E: ch = shift ? 8'h5F : 8'h2D;
        8'h55: ch = shift ? 8'h2B : 8'h3D;
        8'h54: ch = shift ? 8'h7B : 8'h5B;
        8'h5B: ch = shift ? 8'h7D : 8'h5D;
        8'h5D: ch = shift ? 8'h7C : 8'h5C;
        8'h4C: ch = shift ? 8'h3A : 8'h3B;
        8'h52: ch = shift ? 8'h22 : 8'h27;
        8'h41: ch = shift ? 8'h3C : 8'h2C;
        8'h49: ch = shift ? 8'h3E : 8'h2E;
        8'h4A: ch = shift ? 8'h3F : 8'h2F;
        8'h29: ch = 8'h20;
        8'h5A: ch = 8'h0D;
        8'h66: ch = 8'h08;
        8'h0D: ch = 8'h09;
        8'h76: ch = 8'h1B;
        default: v = 1'b0;
      endcase
    end
    // Alt acts on the already ctrl-translated character.
    if (v && alt) begin
      if (ALT_MODE == 1)      ch[7] = 1'b1;
      else if (ALT_MODE == 2) v = 1'b0;
    end
    return {v, ch};
  endfunction

  logic shl_q, shl_d, shr_q, shr_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic caps_q, caps_d, held_q, held_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  logic [8:0]  xl;
  logic        produce, empty, full, push, pop, ovf_set;
  logic [AW:0] count;

  // Modifier next state; translation below still sees the _q values.
  always_comb begin
    shl_d  = shl_q;
    shr_d  = shr_q;
    ctrl_d = ctrl_q;
    alt_d  = alt_q;
    caps_d = caps_q;
    held_d = held_q;
    if (key_data_stb) begin
      if (!key_extended) begin
        case (key_data)
          8'h12: shl_d  = ~key_broken;
          8'h59: shr_d  = ~key_broken;
          8'h14: ctrl_d = ~key_broken;
          8'h11: alt_d  = ~key_broken;
          8'h58: begin
            if (key_broken) begin
              held_d = 1'b0;
            end else if (!held_q) begin
              caps_d = ~caps_q;
              held_d = 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        case (key_data)
          8'h14: ctrl_d = ~key_broken;
          8'h11: alt_d  = ~key_broken;
          default: ;
        endcase
      end
    end
  end

  // FIFO control: pointers carry an extra wrap bit so count = wr - rd.
  always_comb begin
    xl       = xlate(key_data, key_extended, shl_q | shr_q, caps_q, ctrl_q, alt_q);
    produce  = key_data_stb & ~key_broken & xl[8];
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (count == '0);
    full     = (count == (AW + 1)'(FIFO_DEPTH));
    pop      = ~empty & ascii_ready;
    push     = produce & (~full | pop);
    ovf_set  = produce & full & ~pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = ovf_set | (ovf_q & ~overflow_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shl_q    <= 1'b0;
      shr_q    <= 1'b0;
      ctrl_q   <= 1'b0;
      alt_q    <= 1'b0;
      caps_q   <= 1'b0;
      held_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      shl_q    <= shl_d;
      shr_q    <= shr_d;
      ctrl_q   <= ctrl_d;
      alt_q    <= alt_d;
      caps_q   <= caps_d;
      held_q   <= held_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the head output is gated while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= xl[7:0];
  end

  assign ascii_valid = ~empty;
  assign ascii_data  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_count  = count;
  assign overflow    = ovf_q;
  assign caps_led    = caps_q;

endmodule
